// File: rtl/instr_fetch.sv
// instr_fetch -- instruction fetch sequencer for the multicycle RV32 core.
//
// Holds the program counter, fetches one instruction word per instruction
// through a request/valid handshake, and presents it on instr for exactly
// CYCLES_PER_INSTR execute cycles. On the last execute cycle the PC advances
// to PC+4, or to the word-aligned ALU branch target when PCSel is high.
//
// Ports:
//   clk          in   1  clock, rising edge
//   rst          in   1  synchronous active-high reset
//   PCSel        in   1  1 = take branch target (sampled on last EXEC cycle only)
//   alu_out      in  32  branch target from the datapath ALU
//   imem_addr    out 32  fetch address (same as pc)
//   imem_req     out  1  fetch request
//   imem_rdata   in  32  instruction word from memory
//   imem_valid   in   1  imem_rdata valid (ignored unless imem_req is high)
//   instr        out 32  current instruction, NOP_INSTR outside EXEC
//   pc           out 32  address of the current instruction
//   phase        out  3  execute cycle index, 0 outside EXEC
//   instr_start  out  1  one-cycle pulse on phase 0 of each EXEC
//   retired      out 32  completed-instruction count, wraps
module instr_fetch #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int          CYCLES_PER_INSTR = 5,
  parameter logic [31:0] NOP_INSTR        = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSel,
  input  logic [31:0] alu_out,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [2:0]  phase,
  output logic        instr_start,
  output logic [31:0] retired
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  localparam logic [2:0] LAST_PHASE = 3'(CYCLES_PER_INSTR - 1);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] retired_reg;
  logic [2:0]  phase_reg, phase_next;
  logic        start_reg, start_next;
  logic        req_reg, req_next;
  logic        retire_en;
  logic        fetch_done;
  logic        last_exec;

  // A word is only accepted while we are actually requesting one; a stray
  // valid during EXEC or in the dead cycle after reset is ignored.
  assign fetch_done = (state_reg == S_FETCH) && req_reg && imem_valid;
  assign last_exec  = (state_reg == S_EXEC) && (phase_reg == LAST_PHASE);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      pc_reg    <= RESET_PC;
      instr_reg <= NOP_INSTR;
      phase_reg <= 3'd0;
      start_reg <= 1'b0;
      req_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      phase_reg <= phase_next;
      start_reg <= start_next;
      req_reg   <= req_next;
    end
  end

  // The retire counter only moves on its enable, so it holds its value in
  // every cycle that does not complete an instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_reg <= 32'd0;
    end else if (retire_en) begin
      retired_reg <= retired_reg + 32'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: if (fetch_done) state_next = S_EXEC;
      S_EXEC:  if (last_exec)  state_next = S_FETCH;
      default: state_next = S_FETCH;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    pc_next    = pc_reg;
    instr_next = instr_reg;
    phase_next = phase_reg;
    start_next = 1'b0;
    req_next   = req_reg;
    retire_en  = 1'b0;
    case (state_reg)
      S_FETCH: begin
        instr_next = NOP_INSTR;
        phase_next = 3'd0;
        if (fetch_done) begin
          instr_next = imem_rdata;
          start_next = 1'b1;
          req_next   = 1'b0;
        end else begin
          req_next = 1'b1;
        end
      end
      S_EXEC: begin
        if (last_exec) begin
          // Masking keeps the target word aligned; the ALU's low bits are
          // dropped without complaint.
          pc_next    = PCSel ? (alu_out & 32'hFFFF_FFFC) : (pc_reg + 32'd4);
          retire_en  = 1'b1;
          instr_next = NOP_INSTR;
          phase_next = 3'd0;
          req_next   = 1'b1;
        end else begin
          phase_next = phase_reg + 3'd1;
        end
      end
      default: begin
        instr_next = NOP_INSTR;
        phase_next = 3'd0;
      end
    endcase
  end

  assign imem_addr   = pc_reg;
  assign imem_req    = req_reg;
  assign instr       = instr_reg;
  assign pc          = pc_reg;
  assign phase       = phase_reg;
  assign instr_start = start_reg;
  assign retired     = retired_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch. The bench plays instruction memory and the
// control unit; expected pc/retired/instr are tracked per instruction from
// the architectural rules (next pc = target rounded down to a word, or
// pc + 4 mod 2^32; retired counts completions).
module tb_instr_fetch;

  localparam int          CPI  = 5;
  localparam logic [31:0] RPC  = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSel;
  logic [31:0] alu_out;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [2:0]  phase;
  logic        instr_start;
  logic [31:0] retired;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  instr_fetch #(
    .RESET_PC(RPC),
    .CYCLES_PER_INSTR(CPI),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PCSel(PCSel),
    .alu_out(alu_out),
    .imem_addr(imem_addr),
    .imem_req(imem_req),
    .imem_rdata(imem_rdata),
    .imem_valid(imem_valid),
    .instr(instr),
    .pc(pc),
    .phase(phase),
    .instr_start(instr_start),
    .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full instruction, entered in FETCH with imem_req already high.
  // junk_phase: non-last phase where PCSel is pulsed (-1 none, -2 random).
  task automatic do_instr(input int waits, input logic [31:0] word, input bit take,
                          input logic [31:0] tgt, input bit spurious,
                          input int junk_phase, input bit do_force);
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    check("fetch_instr", instr, NOP);
    for (int w = 0; w < waits; w++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      step();
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_instr", instr, NOP);
      check("wait_start", {31'd0, instr_start}, 32'd0);
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    step();
    for (int p = 0; p < CPI; p++) begin
      check("exec_instr", instr, word);
      check("exec_phase", {29'd0, phase}, p);
      check("exec_start", {31'd0, instr_start}, (p == 0) ? 32'd1 : 32'd0);
      check("exec_req", {31'd0, imem_req}, 32'd0);
      check("exec_pc", pc, exp_pc);
      check("exec_retired", retired, exp_ret);
      imem_valid = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = $urandom;
      if (p == CPI - 1) begin
        PCSel   = take;
        alu_out = tgt;
      end else begin
        PCSel   = (junk_phase == -2) ? 1'($urandom_range(0, 1)) : (junk_phase == p);
        alu_out = $urandom;
      end
      if (do_force && p == 1) begin
        force dut.retired_reg = 32'hFFFF_FFFF;
        exp_ret = 32'hFFFF_FFFF;
      end
      if (do_force && p == 2) release dut.retired_reg;
      step();
    end
    PCSel      = 1'b0;
    imem_valid = 1'b0;
    exp_pc  = take ? (tgt - (tgt % 32'd4)) : (exp_pc + 32'd4);
    exp_ret = exp_ret + 32'd1;
    check("next_pc", pc, exp_pc);
    check("next_addr", imem_addr, exp_pc);
    check("next_retired", retired, exp_ret);
    check("next_req", {31'd0, imem_req}, 32'd1);
    check("next_instr", instr, NOP);
    check("next_phase", {29'd0, phase}, 32'd0);
    check("next_start", {31'd0, instr_start}, 32'd0);
    $display("[TB] instr %h waits=%0d take=%0d -> pc=%h retired=%0d", word, waits, take, pc, retired);
  endtask

  initial begin
    rst        = 1'b1;
    PCSel      = 1'b0;
    alu_out    = 32'd0;
    imem_rdata = 32'd0;
    imem_valid = 1'b0;
    exp_pc     = RPC;
    exp_ret    = 32'd0;

    // Reset values
    step();
    check("rst_pc", pc, RPC);
    check("rst_instr", instr, NOP);
    check("rst_phase", {29'd0, phase}, 32'd0);
    check("rst_start", {31'd0, instr_start}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    step();
    check("rel_req", {31'd0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, RPC);
    $display("[TB] reset released, pc=%h req=%0d", pc, imem_req);

    // Reset coincident with valid: word discarded
    rst        = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    check("rstv_instr", instr, NOP);
    check("rstv_phase", {29'd0, phase}, 32'd0);
    check("rstv_start", {31'd0, instr_start}, 32'd0);
    check("rstv_pc", pc, RPC);
    rst        = 1'b0;
    imem_valid = 1'b0;
    step();
    check("rstv_req", {31'd0, imem_req}, 32'd1);
    $display("[TB] reset with valid: instr=%h", instr);

    // Reset at phase 2: not retired, PCSel ignored
    imem_valid = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_valid = 1'b0;
    step();
    step();
    check("mid_phase", {29'd0, phase}, 32'd2);
    check("mid_instr", instr, 32'h1234_5678);
    rst     = 1'b1;
    PCSel   = 1'b1;
    alu_out = 32'h0000_0100;
    step();
    check("mid_pc", pc, RPC);
    check("mid_instr_nop", instr, NOP);
    check("mid_phase0", {29'd0, phase}, 32'd0);
    check("mid_retired", retired, 32'd0);
    rst   = 1'b0;
    PCSel = 1'b0;
    step();
    check("mid_req", {31'd0, imem_req}, 32'd1);
    check("mid_addr", imem_addr, RPC);
    $display("[TB] reset mid-EXEC: pc=%h retired=%0d", pc, retired);

    // pc wraps from FFFF_FFFC to 0, then the two directed words at 0 and 4
    do_instr(0, 32'h0000_0093, 1'b0, 32'd0, 1'b0, -1, 1'b0);
    check("wrap_pc", pc, 32'd0);
    do_instr(0, 32'h0050_0093, 1'b0, 32'd0, 1'b0, -1, 1'b0);
    do_instr(0, 32'h00A0_0113, 1'b0, 32'd0, 1'b0, -1, 1'b0);
    check("seq_pc", pc, 32'd8);
    // Branch taken with misaligned target, then PCSel only on phase 2
    do_instr(0, 32'h0000_0063, 1'b1, 32'h0000_0043, 1'b0, -1, 1'b0);
    check("branch_pc", pc, 32'h0000_0040);
    do_instr(0, 32'h0000_0063, 1'b0, 32'h0000_0200, 1'b0, 2, 1'b0);
    check("junk_pc", pc, 32'h0000_0044);
    // Three wait states, spurious valids during EXEC
    do_instr(3, 32'h0010_0113, 1'b0, 32'd0, 1'b1, -1, 1'b0);
    // retired wrap via forced preload
    do_instr(1, 32'h0020_0193, 1'b0, 32'd0, 1'b0, -1, 1'b1);
    check("ret_wrap", retired, 32'd0);

    // Randomized instructions
    for (int i = 0; i < 40; i++) begin
      do_instr($urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)), $urandom,
               1'b1, -2, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
